// File: rtl/ps2io_fifo.sv
// ---------------------------------------------------------------------------
// ps2io_fifo
//   CPU-facing register front end for a PS/2 core: a receive FIFO fed by the
//   PS/2 receiver, a single-byte transmit path with ack/timeout handling,
//   sticky error flags and a level interrupt.
//
// Ports
//   clk, rst        : system clock (rising edge), asynchronous active-high reset
//   AD, DI, DO      : register address, CPU write data, registered read data
//   rw, cs          : 1 = read / 0 = write, chip select (one access per cs rise)
//   irq             : level interrupt request
//   rx_strobe,
//   rx_byte         : one-cycle received-byte pulse from the PS/2 core
//   tx_req, tx_byte,
//   tx_ack          : transmit handshake to the PS/2 core
//   ps2_timeout     : line-timeout indication from the PS/2 core
//
// Register map
//   $0 R pop RX head (0x00 when empty)      $0 W transmit byte
//   $1 R {IRQ,IEN_RX,RDY,BSY,TOU,OVR,TXERR,FULL}, clears OVR/TXERR/TXDONE
//   $1 W DI[6] IEN_RX, DI[5] IEN_TX, DI[0] FLUSH
//   $2 R FIFO count                          $3..$7 R 0x00, writes ignored
// ---------------------------------------------------------------------------
module ps2io_fifo #(
  parameter int DEPTH      = 8,
  parameter int TX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       rx_strobe,
  input  logic [7:0] rx_byte,
  output logic       tx_req,
  output logic [7:0] tx_byte,
  input  logic       tx_ack,
  input  logic       ps2_timeout
);

  localparam int              PW           = $clog2(DEPTH);
  localparam int              CW           = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C      = CW'(DEPTH);
  localparam logic [15:0]     TIMEOUT_LAST = 16'(TX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_t;

  // Registers
  logic            cs_prev_r;
  logic [7:0]      mem_r [0:DEPTH-1];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            ovr_r;
  logic            txerr_r;
  logic            txdone_r;
  logic            ien_rx_r;
  logic            ien_tx_r;
  tx_state_t       state_r;
  logic [15:0]     wait_cnt_r;
  logic [7:0]      do_r;
  logic            tx_req_r;
  logic [7:0]      tx_byte_r;

  // Combinational signals
  logic            strobe_s;
  logic            rd_stb_s;
  logic            wr_stb_s;
  logic            empty_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic            flush_s;
  logic            ovr_set_s;
  logic            stat_rd_s;
  logic            tx_wr_s;
  logic            cfg_wr_s;
  logic            bsy_s;
  logic [7:0]      status_s;
  logic [7:0]      rd_data_s;
  tx_state_t       state_next_s;
  logic [15:0]     wait_cnt_next_s;
  logic            load_tx_s;
  logic            txdone_set_s;
  logic            txerr_fsm_s;
  logic            txerr_set_s;

  // An access is the first cycle of a cs-high run, so a long cs pulse acts once.
  assign strobe_s  = cs & ~cs_prev_r;
  assign rd_stb_s  = strobe_s & rw;
  assign wr_stb_s  = strobe_s & ~rw;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == DEPTH_C);

  assign pop_s     = rd_stb_s & (AD == 3'd0) & ~empty_s;
  assign stat_rd_s = rd_stb_s & (AD == 3'd1);
  assign tx_wr_s   = wr_stb_s & (AD == 3'd0);
  assign cfg_wr_s  = wr_stb_s & (AD == 3'd1);
  assign flush_s   = cfg_wr_s & DI[0];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_s    = rx_strobe & (~full_s | pop_s);
  assign ovr_set_s = rx_strobe & full_s & ~pop_s;

  assign bsy_s       = (state_r != ST_IDLE);
  assign txerr_set_s = txerr_fsm_s | (tx_wr_s & bsy_s);

  assign irq      = (ien_rx_r & ~empty_s) | (ien_tx_r & txdone_r);
  assign status_s = {irq, ien_rx_r, ~empty_s, bsy_s, ps2_timeout, ovr_r, txerr_r, full_s};

  assign DO      = do_r;
  assign tx_req  = tx_req_r;
  assign tx_byte = tx_byte_r;

  // Read-data multiplexer for the addressed register.
  always_comb begin
    rd_data_s = 8'h00;
    case (AD)
      3'd0: begin
        if (empty_s) begin
          rd_data_s = 8'h00;
        end else begin
          rd_data_s = mem_r[rd_ptr_r];
        end
      end
      3'd1:    rd_data_s = status_s;
      3'd2:    rd_data_s = 8'(count_r);
      default: rd_data_s = 8'h00;
    endcase
  end

  // Transmit FSM next-state logic and event flags.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    load_tx_s       = 1'b0;
    txdone_set_s    = 1'b0;
    txerr_fsm_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_wr_s) begin
          load_tx_s    = 1'b1;
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_next_s    = ST_WAIT;
        wait_cnt_next_s = 16'd0;
      end
      ST_WAIT: begin
        // An ack arriving alongside a timeout still counts as a clean transfer.
        if (tx_ack) begin
          txdone_set_s = 1'b1;
          state_next_s = ST_IDLE;
        end else if (ps2_timeout || (wait_cnt_r == TIMEOUT_LAST)) begin
          txdone_set_s = 1'b1;
          txerr_fsm_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          wait_cnt_next_s = wait_cnt_r + 16'd1;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        wait_cnt_next_s = 16'd0;
      end
    endcase
  end

  // Transmit FSM state, wait counter, request pulse and latched byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 16'd0;
      tx_req_r   <= 1'b0;
      tx_byte_r  <= 8'h00;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      // tx_req is high exactly while the FSM sits in REQ.
      tx_req_r   <= (state_next_s == ST_REQ);
      if (load_tx_s) begin
        tx_byte_r <= DI;
      end else begin
        tx_byte_r <= tx_byte_r;
      end
    end
  end

  // Access edge detector and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_prev_r <= 1'b0;
      do_r      <= 8'h00;
    end else begin
      cs_prev_r <= cs;
      if (rd_stb_s) begin
        do_r <= rd_data_s;
      end else begin
        do_r <= do_r;
      end
    end
  end

  // FIFO pointers and occupancy; flush overrides any same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push_s && !flush_s) begin
      mem_r[wr_ptr_r] <= rx_byte;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Sticky flags and interrupt enables; a new event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_r    <= 1'b0;
      txerr_r  <= 1'b0;
      txdone_r <= 1'b0;
      ien_rx_r <= 1'b0;
      ien_tx_r <= 1'b0;
    end else begin
      ovr_r    <= ovr_set_s    | (ovr_r    & ~stat_rd_s);
      txerr_r  <= txerr_set_s  | (txerr_r  & ~stat_rd_s);
      txdone_r <= txdone_set_s | (txdone_r & ~stat_rd_s);
      if (cfg_wr_s) begin
        ien_rx_r <= DI[6];
        ien_tx_r <= DI[5];
      end else begin
        ien_rx_r <= ien_rx_r;
        ien_tx_r <= ien_tx_r;
      end
    end
  end

endmodule

// File: tb/tb_ps2io_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2io_fifo
//   Directed bench for ps2io_fifo (DEPTH=8, TX_TIMEOUT=16). A queue-based
//   model of the register block is stepped once per clock from the stimulus
//   process; DO, irq, tx_req and tx_byte are compared against it one time unit
//   after every rising edge. Hand-computed literals pin the model as well.
// ---------------------------------------------------------------------------
module tb_ps2io_fifo;

  localparam int DEPTH = 8;
  localparam int TXTO  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;
  logic       rx_strobe;
  logic [7:0] rx_byte;
  logic       tx_req;
  logic [7:0] tx_byte;
  logic       tx_ack;
  logic       ps2_timeout;

  always #5 clk = ~clk;

  ps2io_fifo #(.DEPTH(DEPTH), .TX_TIMEOUT(TXTO)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .irq(irq), .rx_strobe(rx_strobe), .rx_byte(rx_byte), .tx_req(tx_req),
    .tx_byte(tx_byte), .tx_ack(tx_ack), .ps2_timeout(ps2_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  byte unsigned q[$];
  bit           m_ovr, m_txerr, m_txdone, m_ien_rx, m_ien_tx, m_cs_prev, m_tx_req;
  int           m_phase;   // 0 idle, 1 requesting, 2 waiting for ack
  int           m_wait;
  logic [7:0]   m_do, m_txb;

  function automatic bit m_irq();
    return (m_ien_rx && q.size() != 0) || (m_ien_tx && m_txdone);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 1'b0; m_txerr = 1'b0; m_txdone = 1'b0;
    m_ien_rx = 1'b0; m_ien_tx = 1'b0; m_cs_prev = 1'b0; m_tx_req = 1'b0;
    m_phase = 0; m_wait = 0; m_do = 8'h00; m_txb = 8'h00;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit         stb, rd, wr, pop, flush, stat_rd, tx_wr, drop;
    logic [7:0] rv;
    stb = cs && !m_cs_prev;
    m_cs_prev = cs;
    rd = stb && rw;
    wr = stb && !rw;
    case (AD)
      3'd0:    rv = (q.size() != 0) ? q[0] : 8'h00;
      3'd1:    rv = {m_irq(), m_ien_rx, q.size() != 0, m_phase != 0, ps2_timeout,
                     m_ovr, m_txerr, q.size() == DEPTH};
      3'd2:    rv = 8'(q.size());
      default: rv = 8'h00;
    endcase
    if (rd) m_do = rv;
    pop     = rd && (AD == 3'd0) && (q.size() != 0);
    stat_rd = rd && (AD == 3'd1);
    tx_wr   = wr && (AD == 3'd0);
    flush   = wr && (AD == 3'd1) && DI[0];
    drop    = rx_strobe && (q.size() == DEPTH) && !pop;
    if (stat_rd) begin
      m_ovr = 1'b0; m_txerr = 1'b0; m_txdone = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    if (pop) void'(q.pop_front());
    if (rx_strobe && !drop) q.push_back(rx_byte);
    if (flush) q.delete();
    if (wr && (AD == 3'd1)) begin
      m_ien_rx = DI[6];
      m_ien_tx = DI[5];
    end
    if (tx_wr && m_phase != 0) m_txerr = 1'b1;
    case (m_phase)
      0: if (tx_wr) begin m_txb = DI; m_phase = 1; end
      1: begin m_phase = 2; m_wait = 0; end
      default: begin
        if (tx_ack) begin
          m_txdone = 1'b1; m_phase = 0;
        end else if (ps2_timeout || m_wait == TXTO - 1) begin
          m_txdone = 1'b1; m_txerr = 1'b1; m_phase = 0;
        end else begin
          m_wait++;
        end
      end
    endcase
    m_tx_req = (m_phase == 1);
  endtask

  // One clock: step the model, take the edge, compare outputs away from it.
  task automatic tick();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    chk("cyc DO", DO, m_do);
    chk("cyc irq", 8'(irq), 8'(m_irq()));
    chk("cyc tx_req", 8'(tx_req), 8'(m_tx_req));
    chk("cyc tx_byte", tx_byte, m_txb);
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [7:0] exp, input string name);
    cs = 1'b1; rw = 1'b1; AD = a;
    tick();
    chk(name, DO, exp);
    cs = 1'b0;
    tick();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    tick();
    cs = 1'b0; rw = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] b);
    rx_strobe = 1'b1; rx_byte = b;
    tick();
    rx_strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; AD = 3'd0; DI = 8'h00; rw = 1'b1; cs = 1'b0;
    rx_strobe = 1'b0; rx_byte = 8'h00; tx_ack = 1'b0; ps2_timeout = 1'b0;
    model_reset();
    tick(); tick();
    chk("rst DO", DO, 8'h00);
    chk("rst irq", 8'(irq), 8'h00);
    chk("rst tx_req", 8'(tx_req), 8'h00);
    chk("rst tx_byte", tx_byte, 8'h00);
    rst = 1'b0;
    tick();

    // Basic push / pop / empty read
    push(8'h1C); push(8'h32);
    rd_reg(3'd2, 8'h02, "count2");
    rd_reg(3'd0, 8'h1C, "pop1");
    rd_reg(3'd0, 8'h32, "pop2");
    rd_reg(3'd0, 8'h00, "pop_empty");
    rd_reg(3'd2, 8'h00, "count0");
    rd_reg(3'd5, 8'h00, "unused_reg");

    // Overflow, sticky OVR, pop+push when full
    for (int i = 0; i < DEPTH + 1; i++) push(8'(8'h10 + i));
    rd_reg(3'd1, 8'h25, "status_ovr");
    rd_reg(3'd1, 8'h21, "status_ovr_clr");
    rd_reg(3'd2, 8'h08, "count_full");
    cs = 1'b1; rw = 1'b1; AD = 3'd0; rx_strobe = 1'b1; rx_byte = 8'h99;
    tick();
    chk("pop_push_full", DO, 8'h10);
    cs = 1'b0; rx_strobe = 1'b0;
    tick();
    rd_reg(3'd2, 8'h08, "count_after_pp");
    rd_reg(3'd1, 8'h21, "status_no_ovr");
    rd_reg(3'd0, 8'h11, "pop_order");
    cs = 1'b1; rw = 1'b0; AD = 3'd1; DI = 8'h01; rx_strobe = 1'b1; rx_byte = 8'h77;
    tick();
    cs = 1'b0; rw = 1'b1; rx_strobe = 1'b0;
    tick();
    rd_reg(3'd2, 8'h00, "flush_wins");

    // RX interrupt and long cs pulse
    wr_reg(3'd1, 8'h40);
    push(8'hAA);
    chk("irq_rx", 8'(irq), 8'h01);
    push(8'hBB);
    cs = 1'b1; rw = 1'b1; AD = 3'd0;
    repeat (5) tick();
    chk("long_cs_pop", DO, 8'hAA);
    cs = 1'b0;
    tick();
    rd_reg(3'd2, 8'h01, "long_cs_count");
    chk("irq_rx_still", 8'(irq), 8'h01);
    rd_reg(3'd0, 8'hBB, "pop_bb");
    chk("irq_rx_clear", 8'(irq), 8'h00);

    // Transmit with ack, busy write rejected
    wr_reg(3'd1, 8'h20);
    cs = 1'b1; rw = 1'b0; AD = 3'd0; DI = 8'hED;
    tick();
    chk("tx_req_pulse", 8'(tx_req), 8'h01);
    chk("tx_byte_ed", tx_byte, 8'hED);
    cs = 1'b0; rw = 1'b1;
    tick();
    chk("tx_req_drop", 8'(tx_req), 8'h00);
    rd_reg(3'd1, 8'h10, "status_bsy");
    wr_reg(3'd0, 8'hF4);
    chk("tx_byte_kept", tx_byte, 8'hED);
    rd_reg(3'd1, 8'h12, "status_txerr");
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("irq_txdone", 8'(irq), 8'h01);
    rd_reg(3'd1, 8'h80, "status_done");
    chk("irq_tx_clear", 8'(irq), 8'h00);

    // Timeout after exactly 16 WAIT cycles
    cs = 1'b1; rw = 1'b0; AD = 3'd0; DI = 8'h55;
    tick();
    cs = 1'b0; rw = 1'b1;
    tick();
    repeat (15) tick();
    chk("timeout_not_yet", 8'(irq), 8'h00);
    tick();
    chk("timeout_fired", 8'(irq), 8'h01);
    rd_reg(3'd1, 8'h82, "status_timeout");
    rd_reg(3'd1, 8'h00, "status_cleared");

    // Line timeout: TOU bit, abort in WAIT, ack beats timeout
    ps2_timeout = 1'b1;
    rd_reg(3'd1, 8'h08, "status_tou");
    ps2_timeout = 1'b0;
    wr_reg(3'd0, 8'h66);
    chk("tx_byte_66", tx_byte, 8'h66);
    ps2_timeout = 1'b1;
    tick();
    ps2_timeout = 1'b0;
    chk("irq_ps2_to", 8'(irq), 8'h01);
    rd_reg(3'd1, 8'h82, "status_ps2_to");
    wr_reg(3'd0, 8'h67);
    tx_ack = 1'b1; ps2_timeout = 1'b1;
    tick();
    tx_ack = 1'b0; ps2_timeout = 1'b0;
    rd_reg(3'd1, 8'h80, "ack_beats_to");

    // Reset in the middle of a transmit
    wr_reg(3'd1, 8'h60);
    push(8'h5A);
    wr_reg(3'd0, 8'h77);
    tick(); tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst tx_req", 8'(tx_req), 8'h00);
    chk("arst tx_byte", tx_byte, 8'h00);
    chk("arst DO", DO, 8'h00);
    chk("arst irq", 8'(irq), 8'h00);
    tick();
    rst = 1'b0;
    tick();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    rd_reg(3'd1, 8'h00, "status_after_rst");
    rd_reg(3'd2, 8'h00, "count_after_rst");
    chk("late_ack_irq", 8'(irq), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2io_fifo.md
PS2IO_FIFO -- requirements
Module: ps2io_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: RX FIFO depth in bytes; power of two, 2..128.
REQ-002 The block SHALL have parameter TX_TIMEOUT, default 50000: clk cycles to wait for tx_ack before aborting a transmit; 1..65535.
REQ-003 The block SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port AD, input, 3: register address.
REQ-006 The block SHALL have port DI, input, 8: CPU write data.
REQ-007 The block SHALL have port DO, output, 8: CPU read data, registered.
REQ-008 The block SHALL have port rw, input, 1: 1 = read, 0 = write.
REQ-009 The block SHALL have port cs, input, 1: chip select; may stay high for several cycles per access.
REQ-010 The block SHALL have port irq, output, 1: level interrupt request, active-high.
REQ-011 The block SHALL have ports rx_strobe (input, 1) and rx_byte (input, 8): one-cycle pulse from the PS/2 core with the received byte.
REQ-012 The block SHALL have ports tx_req (output, 1), tx_byte (output, 8) and tx_ack (input, 1): transmit handshake to the PS/2 core.
REQ-013 The block SHALL have port ps2_timeout, input, 1: line-timeout indication from the PS/2 core.

Function
REQ-014 An access strobe SHALL be cs high with cs low in the previous cycle; all register side effects SHALL occur only on the strobe cycle, so one access produces exactly one side effect.
REQ-015 On a read strobe, DO SHALL load the addressed value at that clock edge; DO SHALL hold its value otherwise.
REQ-016 Register map: $0 R = pop RX FIFO head; $0 W = transmit byte; $1 R = status {IRQ,IEN_RX,RDY,BSY,TOU,OVR,TXERR,FULL}; $1 W = DI[6] IEN_RX, DI[5] IEN_TX, DI[0] FLUSH; $2 R = FIFO count, zero-extended; $3..$7 R = 0x00, writes ignored.
REQ-017 RDY SHALL equal FIFO not empty, FULL SHALL equal count==DEPTH, BSY SHALL equal TX FSM not IDLE, and TOU SHALL equal ps2_timeout.
REQ-018 A rx_strobe with FIFO not full SHALL push rx_byte; with FIFO full the byte SHALL be dropped and sticky OVR set.
REQ-019 A read of $0 with FIFO empty SHALL return 0x00 and not change count.
REQ-020 A pop and a push in the same cycle SHALL both take effect, count unchanged, including when full (push accepted) and when empty (push only).
REQ-021 Pointers SHALL wrap modulo DEPTH; count width SHALL be clog2(DEPTH)+1.
REQ-022 FLUSH SHALL empty the FIFO in one cycle and win over a same-cycle push; FLUSH is not stored.
REQ-023 A read of $1 SHALL return the pre-clear value, then clear OVR, TXERR and TXDONE.
REQ-024 The TX FSM SHALL have states IDLE, REQ and WAIT.
REQ-025 A $0 write in IDLE SHALL latch DI to tx_byte and move to REQ; REQ SHALL assert tx_req for exactly one cycle, then move to WAIT with the wait counter at 0.
REQ-026 In WAIT, tx_ack SHALL set TXDONE and return to IDLE; ps2_timeout, or the counter reaching TX_TIMEOUT-1, SHALL set TXERR and TXDONE and return to IDLE; tx_ack SHALL win if both occur in the same cycle.
REQ-027 A $0 write while BSY SHALL be discarded and SHALL set TXERR; tx_byte SHALL remain unchanged.
REQ-028 irq SHALL equal (IEN_RX & RDY) | (IEN_TX & TXDONE), combinational from registers; the IRQ status bit SHALL equal irq.

Reset
REQ-029 rst SHALL asynchronously set: DO=0x00, tx_req=0, tx_byte=0x00, FIFO empty, pointers 0, OVR=TXERR=TXDONE=0, IEN_RX=IEN_TX=0, FSM=IDLE, counter=0, previous-cs register=0; irq=0.
REQ-030 Reset asserted mid-transmit SHALL abort it; a late tx_ack after release SHALL be ignored in IDLE.

Verification
REQ-031 Push 0x1C,0x32; read $2 -> 0x02; read $0 twice -> 0x1C, 0x32; a third read -> 0x00; $2 -> 0x00.
REQ-032 Push DEPTH+1 bytes -> FULL=1, last byte lost; $1 read shows OVR=1; second $1 read shows OVR=0; a pop plus push in the same cycle when full -> count stays DEPTH.
REQ-033 Write $1=0x40 then push 0xAA -> irq=1 next cycle; read $0 -> irq=0; hold cs high 5 cycles on $0 -> only one pop.
REQ-034 Write $0=0xED -> tx_req pulses 1 cycle with tx_byte=0xED, BSY=1; write $0=0xF4 while busy -> TXERR=1, tx_byte still 0xED; tx_ack -> BSY=0, irq=1 if IEN_TX=1.
REQ-035 With TX_TIMEOUT=16 and no tx_ack -> IDLE after 16 WAIT cycles, TXERR=1; assert rst during WAIT -> tx_req=0, FSM IDLE, all status bits 0.
